// File: rtl/sad_ctrl.sv
// sad_ctrl -- control FSM for the sum-of-absolute-differences engine.
//
// Sequences one SAD run over N_PIX pixels. It drives the datapath strobes,
// generates the pixel address for the A/B block memories, and provides a
// go/busy/done handshake to the system.
//
// Optional feature macro: SAD_CTRL_CYCLE_CNT_EN. When defined, a 16-bit
// busy-cycle counter is added and the cycles_o port is exposed.
//
// Parameters:
//   N_PIX         pixels per block (number of loop iterations)
//   AW            address width, $clog2(N_PIX)
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   go_i          start request, sampled only in IDLE
//   abort_i       cancels a run in progress (ignored in IDLE)
//   i_it_256_i    datapath loop-continue flag (1 = more pixels remain)
//   sum_clr_o     datapath strobe, high in INIT
//   i_clr_o       datapath strobe, high in INIT
//   sum_ld_o      datapath strobe, high in ACCUM
//   i_inc_o       datapath strobe, high in ACCUM
//   sad_reg_ld_o  datapath strobe, high in STORE
//   addr_o        pixel address to block memories A and B
//   busy_o        high whenever the FSM is not in IDLE
//   done_o        one-cycle pulse after a completed run
//   err_o         sticky loop-overrun flag, cleared when go_i is accepted
//   cycles_o      busy-cycle count of the last completed run (optional)
module sad_ctrl #(
  parameter int unsigned N_PIX = 256,
  parameter int unsigned AW    = $clog2(N_PIX)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          go_i,
  input  logic          abort_i,
  input  logic          i_it_256_i,
  output logic          sum_clr_o,
  output logic          i_clr_o,
  output logic          sum_ld_o,
  output logic          i_inc_o,
  output logic          sad_reg_ld_o,
  output logic [AW-1:0] addr_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
`ifdef SAD_CTRL_CYCLE_CNT_EN
  ,
  output logic [15:0]   cycles_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CHECK,
    ACCUM,
    STORE
  } state_t;

  localparam logic [AW:0] N_LAST = (AW+1)'(N_PIX);

  state_t      state;
  logic [AW:0] idx;

  // Strobe pattern {sum_clr, i_clr, sum_ld, i_inc, sad_reg_ld} for a state.
  function automatic logic [4:0] strb_of(input state_t s);
    case (s)
      INIT:    return 5'b11000;
      ACCUM:   return 5'b00110;
      STORE:   return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  assign addr_o = idx[AW-1:0];

  // Strobes and busy_o are registered from the next state, so each one
  // reads exactly as if it were decoded from the state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      idx    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      {sum_clr_o, i_clr_o, sum_ld_o, i_inc_o, sad_reg_ld_o} <= '0;
    end else begin
      done_o <= 1'b0;
      if (state != IDLE && abort_i) begin
        // Abort outranks every other transition, including leaving STORE.
        state  <= IDLE;
        busy_o <= 1'b0;
        {sum_clr_o, i_clr_o, sum_ld_o, i_inc_o, sad_reg_ld_o} <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (go_i) begin
              state  <= INIT;
              busy_o <= 1'b1;
              err_o  <= 1'b0;
              {sum_clr_o, i_clr_o, sum_ld_o, i_inc_o, sad_reg_ld_o} <= strb_of(INIT);
            end
          end
          INIT: begin
            state <= CHECK;
            idx   <= '0;
            {sum_clr_o, i_clr_o, sum_ld_o, i_inc_o, sad_reg_ld_o} <= strb_of(CHECK);
          end
          CHECK: begin
            if (i_it_256_i && idx != N_LAST) begin
              state <= ACCUM;
              {sum_clr_o, i_clr_o, sum_ld_o, i_inc_o, sad_reg_ld_o} <= strb_of(ACCUM);
            end else begin
              // A continue request after N_PIX iterations is an overrun.
              if (i_it_256_i) begin
                err_o <= 1'b1;
              end
              state <= STORE;
              {sum_clr_o, i_clr_o, sum_ld_o, i_inc_o, sad_reg_ld_o} <= strb_of(STORE);
            end
          end
          ACCUM: begin
            state <= CHECK;
            idx   <= idx + 1'b1;
            {sum_clr_o, i_clr_o, sum_ld_o, i_inc_o, sad_reg_ld_o} <= strb_of(CHECK);
          end
          STORE: begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            {sum_clr_o, i_clr_o, sum_ld_o, i_inc_o, sad_reg_ld_o} <= strb_of(IDLE);
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
            {sum_clr_o, i_clr_o, sum_ld_o, i_inc_o, sad_reg_ld_o} <= '0;
          end
        endcase
      end
    end
  end

`ifdef SAD_CTRL_CYCLE_CNT_EN
  logic [15:0] cyc_cnt;

  // cyc_cnt holds the number of busy cycles before the current one, so
  // the value latched in STORE is cyc_cnt + 1 (STORE itself included).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_cnt  <= '0;
      cycles_o <= '0;
    end else if (state == IDLE) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 16'd1;
      if (state == STORE && !abort_i) begin
        cycles_o <= cyc_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sad_ctrl.sv
module tb_sad_ctrl;

  localparam int unsigned N    = 256;
  localparam int unsigned AW   = 8;
  localparam int          MAXC = 1100;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          go_i;
  logic          abort_i;
  logic          i_it_256_i;
  logic          sum_clr_o, i_clr_o, sum_ld_o, i_inc_o, sad_reg_ld_o;
  logic [AW-1:0] addr_o;
  logic          busy_o, done_o, err_o;
`ifdef SAD_CTRL_CYCLE_CNT_EN
  logic [15:0]   cycles_o;
`endif

  sad_ctrl #(.N_PIX(N), .AW(AW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .go_i         (go_i),
    .abort_i      (abort_i),
    .i_it_256_i   (i_it_256_i),
    .sum_clr_o    (sum_clr_o),
    .i_clr_o      (i_clr_o),
    .sum_ld_o     (sum_ld_o),
    .i_inc_o      (i_inc_o),
    .sad_reg_ld_o (sad_reg_ld_o),
    .addr_o       (addr_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
`ifdef SAD_CTRL_CYCLE_CNT_EN
    ,
    .cycles_o     (cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Datapath model: counter cleared by i_clr, advanced by i_inc, and a
  // continue flag that is high while fewer than dp_lim pixels are done.
  int dp_i;
  int dp_lim = 0;
  bit dp_stuck = 1'b0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        dp_i <= 0;
    else if (i_clr_o) dp_i <= 0;
    else if (i_inc_o) dp_i <= dp_i + 1;
  end

  assign i_it_256_i = dp_stuck || (dp_i < dp_lim);

  // Per-cycle capture, cycle m = m-th cycle after the edge that took go_i.
  logic [6:0]    obs   [0:MAXC];
  logic [AW-1:0] oaddr [0:MAXC];
  logic          oerr  [0:MAXC];

`ifdef SAD_CTRL_CYCLE_CNT_EN
  int exp_cycles = 0;
`endif

  // Reference timing: run accepted at edge k, eff ACCUM iterations,
  // optional abort sampled at the end of cycle ab. Vector layout is
  // {sum_clr, i_clr, sum_ld, i_inc, sad_reg_ld, busy, done}.
  function automatic logic [6:0] ref_vec(input int m, input int eff, input int ab);
    if (m < 1) return 7'b0;
    if (ab > 0 && m > ab) return 7'b0;
    if (m == 1) return 7'b1100010;
    if (m <= 2*eff + 2) return ((m % 2) == 1) ? 7'b0011010 : 7'b0000010;
    if (m == 2*eff + 3) return 7'b0000110;
    if (m == 2*eff + 4) return 7'b0000001;
    return 7'b0;
  endfunction

  function automatic logic [6:0] out_vec();
    return {sum_clr_o, i_clr_o, sum_ld_o, i_inc_o, sad_reg_ld_o, busy_o, done_o};
  endfunction

  task automatic capture(input int ncyc, input int ab, input bit hold);
    go_i = 1'b1;
    @(posedge clk_i);
    #1;
    if (!hold) go_i = 1'b0;
    for (int m = 1; m <= ncyc; m++) begin
      @(negedge clk_i);
      obs[m]   = out_vec();
      oaddr[m] = addr_o;
      oerr[m]  = err_o;
      abort_i  = (m == ab);
    end
    go_i    = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    go_i    = 1'b0;
    abort_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (out_vec() !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", out_vec(), 7'b0);
    end
    checks++;
    if (addr_o !== '0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_addr_err got addr=%0d err=%b exp addr=0 err=0", addr_o, err_o);
    end
`ifdef SAD_CTRL_CYCLE_CNT_EN
    checks++;
    if (cycles_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_cycles got=%0d exp=0", cycles_o);
    end
`endif
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (out_vec() !== 7'b0) begin
      errors++;
      $display("FAIL idle_after_reset got=%b exp=%b", out_vec(), 7'b0);
    end
  endtask

  task automatic test_full_run();
    int n_ld;
    logic [AW-1:0] ea;
    dp_stuck = 1'b0;
    dp_lim   = N;
    capture(530, 0, 1'b0);
    n_ld = 0;
    for (int m = 1; m <= 530; m++) begin
      checks++;
      if (obs[m] !== ref_vec(m, N, 0)) begin
        errors++;
        $display("FAIL full_strobes m=%0d got=%b exp=%b", m, obs[m], ref_vec(m, N, 0));
      end
      if (obs[m][4] === 1'b1) n_ld++;
      if (m >= 2 && m <= 2*N + 2) begin
        ea = AW'((m - 2) / 2);
        checks++;
        if (oaddr[m] !== ea) begin
          errors++;
          $display("FAIL full_addr m=%0d got=%0d exp=%0d", m, oaddr[m], ea);
        end
      end
    end
    checks++;
    if (n_ld != N) begin
      errors++;
      $display("FAIL full_ld_count got=%0d exp=%0d", n_ld, N);
    end
    checks++;
    if (obs[515][2] !== 1'b1 || obs[516][0] !== 1'b1 || obs[517][0] !== 1'b0) begin
      errors++;
      $display("FAIL full_store_done got st515=%b dn516=%b dn517=%b exp 1 1 0",
               obs[515][2], obs[516][0], obs[517][0]);
    end
    checks++;
    if (oerr[530] !== 1'b0) begin
      errors++;
      $display("FAIL full_err got=%b exp=0", oerr[530]);
    end
`ifdef SAD_CTRL_CYCLE_CNT_EN
    exp_cycles = 2*N + 3;
    checks++;
    if (cycles_o !== 16'(exp_cycles)) begin
      errors++;
      $display("FAIL full_cycles got=%0d exp=%0d", cycles_o, exp_cycles);
    end
`endif
  endtask

  task automatic test_random_lengths();
    int len;
    int nc;
    logic [AW-1:0] ea;
    dp_stuck = 1'b0;
    for (int r = 0; r < 4; r++) begin
      len    = (r == 0) ? 0 : int'($urandom_range(1, N - 1));
      dp_lim = len;
      nc     = 2*len + 8;
      capture(nc, 0, 1'b0);
      for (int m = 1; m <= nc; m++) begin
        checks++;
        if (obs[m] !== ref_vec(m, len, 0)) begin
          errors++;
          $display("FAIL len_strobes len=%0d m=%0d got=%b exp=%b", len, m, obs[m], ref_vec(m, len, 0));
        end
        if (m >= 2 && m <= 2*len + 2) begin
          ea = AW'((m - 2) / 2);
          checks++;
          if (oaddr[m] !== ea) begin
            errors++;
            $display("FAIL len_addr len=%0d m=%0d got=%0d exp=%0d", len, m, oaddr[m], ea);
          end
        end
      end
`ifdef SAD_CTRL_CYCLE_CNT_EN
      exp_cycles = 2*len + 3;
      checks++;
      if (cycles_o !== 16'(exp_cycles)) begin
        errors++;
        $display("FAIL len_cycles len=%0d got=%0d exp=%0d", len, cycles_o, exp_cycles);
      end
`endif
    end
  endtask

  task automatic test_abort();
    int ab;
    int len;
    dp_stuck = 1'b0;
    dp_lim   = N;
    capture(300, 203, 1'b0);
    for (int m = 1; m <= 300; m++) begin
      checks++;
      if (obs[m] !== ref_vec(m, N, 203)) begin
        errors++;
        $display("FAIL abort_strobes m=%0d got=%b exp=%b", m, obs[m], ref_vec(m, N, 203));
      end
    end
    checks++;
    if (oaddr[203] !== 8'd100 || obs[203][4] !== 1'b1 || obs[204][1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_point got addr=%0d ld=%b busy_next=%b exp addr=100 ld=1 busy_next=0",
               oaddr[203], obs[203][4], obs[204][1]);
    end
`ifdef SAD_CTRL_CYCLE_CNT_EN
    checks++;
    if (cycles_o !== 16'(exp_cycles)) begin
      errors++;
      $display("FAIL abort_cycles got=%0d exp=%0d", cycles_o, exp_cycles);
    end
`endif
    // Abort at a random point of a full run, up to and including STORE.
    ab = int'($urandom_range(1, 2*N + 3));
    capture(2*N + 8, ab, 1'b0);
    for (int m = 1; m <= 2*N + 8; m++) begin
      checks++;
      if (obs[m] !== ref_vec(m, N, ab)) begin
        errors++;
        $display("FAIL abort_rand ab=%0d m=%0d got=%b exp=%b", ab, m, obs[m], ref_vec(m, N, ab));
      end
    end
    // A following run completes normally.
    len    = int'($urandom_range(1, 40));
    dp_lim = len;
    capture(2*len + 8, 0, 1'b0);
    for (int m = 1; m <= 2*len + 8; m++) begin
      checks++;
      if (obs[m] !== ref_vec(m, len, 0)) begin
        errors++;
        $display("FAIL after_abort len=%0d m=%0d got=%b exp=%b", len, m, obs[m], ref_vec(m, len, 0));
      end
    end
`ifdef SAD_CTRL_CYCLE_CNT_EN
    exp_cycles = 2*len + 3;
    checks++;
    if (cycles_o !== 16'(exp_cycles)) begin
      errors++;
      $display("FAIL after_abort_cycles got=%0d exp=%0d", cycles_o, exp_cycles);
    end
`endif
  endtask

  task automatic test_overrun();
    int n_ld;
    logic ee;
    dp_stuck = 1'b1;
    capture(520, 0, 1'b0);
    n_ld = 0;
    for (int m = 1; m <= 520; m++) begin
      checks++;
      if (obs[m] !== ref_vec(m, N, 0)) begin
        errors++;
        $display("FAIL ovr_strobes m=%0d got=%b exp=%b", m, obs[m], ref_vec(m, N, 0));
      end
      if (obs[m][4] === 1'b1) n_ld++;
      ee = (m >= 2*N + 3);
      checks++;
      if (oerr[m] !== ee) begin
        errors++;
        $display("FAIL ovr_err m=%0d got=%b exp=%b", m, oerr[m], ee);
      end
    end
    checks++;
    if (n_ld != N) begin
      errors++;
      $display("FAIL ovr_ld_count got=%0d exp=%0d", n_ld, N);
    end
`ifdef SAD_CTRL_CYCLE_CNT_EN
    exp_cycles = 2*N + 3;
    checks++;
    if (cycles_o !== 16'(exp_cycles)) begin
      errors++;
      $display("FAIL ovr_cycles got=%0d exp=%0d", cycles_o, exp_cycles);
    end
`endif
    dp_stuck = 1'b0;
    dp_lim   = 3;
    capture(14, 0, 1'b0);
    checks++;
    if (oerr[1] !== 1'b0) begin
      errors++;
      $display("FAIL ovr_err_clear got=%b exp=0", oerr[1]);
    end
    for (int m = 1; m <= 14; m++) begin
      checks++;
      if (obs[m] !== ref_vec(m, 3, 0)) begin
        errors++;
        $display("FAIL ovr_next m=%0d got=%b exp=%b", m, obs[m], ref_vec(m, 3, 0));
      end
    end
`ifdef SAD_CTRL_CYCLE_CNT_EN
    exp_cycles = 9;
`endif
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    dp_stuck = 1'b0;
    dp_lim   = N;
    capture(1032, 0, 1'b1);
    for (int m = 1; m <= 1032; m++) begin
      e = ref_vec(m, N, 0) | ref_vec(m - (2*N + 4), N, 0);
      checks++;
      if (obs[m] !== e) begin
        errors++;
        $display("FAIL b2b_strobes m=%0d got=%b exp=%b", m, obs[m], e);
      end
    end
    checks++;
    if (obs[516][0] !== 1'b1 || obs[517][6:5] !== 2'b11) begin
      errors++;
      $display("FAIL b2b_restart got done516=%b init517=%b exp 1 11", obs[516][0], obs[517][6:5]);
    end
`ifdef SAD_CTRL_CYCLE_CNT_EN
    exp_cycles = 2*N + 3;
    checks++;
    if (cycles_o !== 16'(exp_cycles)) begin
      errors++;
      $display("FAIL b2b_cycles got=%0d exp=%0d", cycles_o, exp_cycles);
    end
`endif
    repeat (4) @(negedge clk_i);
    checks++;
    if (out_vec() !== 7'b0) begin
      errors++;
      $display("FAIL b2b_idle got=%b exp=%b", out_vec(), 7'b0);
    end
  endtask

  task automatic test_async_reset();
    dp_stuck = 1'b0;
    dp_lim   = N;
    go_i     = 1'b1;
    @(posedge clk_i);
    #1;
    go_i = 1'b0;
    repeat (150) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (out_vec() !== 7'b0 || addr_o !== '0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got=%b addr=%0d err=%b exp all 0", out_vec(), addr_o, err_o);
    end
`ifdef SAD_CTRL_CYCLE_CNT_EN
    checks++;
    if (cycles_o !== 16'd0) begin
      errors++;
      $display("FAIL async_rst_cycles got=%0d exp=0", cycles_o);
    end
    exp_cycles = 0;
`endif
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      checks++;
      if (out_vec() !== 7'b0) begin
        errors++;
        $display("FAIL post_rst c=%0d got=%b exp=%b", c, out_vec(), 7'b0);
      end
    end
    dp_lim = 5;
    capture(20, 0, 1'b0);
    for (int m = 1; m <= 20; m++) begin
      checks++;
      if (obs[m] !== ref_vec(m, 5, 0)) begin
        errors++;
        $display("FAIL post_rst_run m=%0d got=%b exp=%b", m, obs[m], ref_vec(m, 5, 0));
      end
    end
`ifdef SAD_CTRL_CYCLE_CNT_EN
    checks++;
    if (cycles_o !== 16'd13) begin
      errors++;
      $display("FAIL post_rst_cycles got=%0d exp=13", cycles_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_random_lengths();
    test_abort();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
